// File: rtl/conv.sv
// Single-channel 2-D valid convolution (stride 1, no padding) with ReLU and unsigned saturation.
// One output pixel is produced per enabled clock, row-major, until the whole map is written.
module conv #(
    parameter int DATA_WIDTH      = 8,
    parameter int IFMAP_SIZE      = 128,
    parameter int KERNEL_SIZE     = 3,
    parameter int CONV_OFMAP_SIZE = IFMAP_SIZE - KERNEL_SIZE + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic        [DATA_WIDTH-1:0] conv_ifmap [IFMAP_SIZE][IFMAP_SIZE],
    input  logic signed [DATA_WIDTH-1:0] weights    [KERNEL_SIZE][KERNEL_SIZE],
    output logic        [DATA_WIDTH-1:0] conv_ofmap [CONV_OFMAP_SIZE][CONV_OFMAP_SIZE],
    output logic                         conv_done
);

    localparam int ROW_W = (CONV_OFMAP_SIZE > 1) ? $clog2(CONV_OFMAP_SIZE) : 1;
    localparam int IDX_W = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    // Wide enough that the full window sum can never overflow.
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE) + 1;

    localparam logic [ROW_W-1:0]        LAST    = ROW_W'(CONV_OFMAP_SIZE - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

    logic        [ROW_W-1:0]      row;
    logic        [ROW_W-1:0]      col;
    logic signed [ACC_W-1:0]      acc;
    logic        [DATA_WIDTH-1:0] pix;
    logic                         step;

    assign step = en && !conv_done;

    // Pixels are zero-extended to signed before multiplying with the signed weights.
    always_comb begin
        acc = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                acc = acc
                    + ACC_W'($signed({1'b0, conv_ifmap[IDX_W'(row) + IDX_W'(i)]
                                                      [IDX_W'(col) + IDX_W'(j)]}))
                    * ACC_W'(weights[i][j]);
            end
        end
    end

    always_comb begin
        pix = acc[DATA_WIDTH-1:0];
        if (acc < 0) begin
            pix = '0;
        end else if (acc > PIX_MAX) begin
            pix = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            conv_done <= 1'b0;
            for (int r = 0; r < CONV_OFMAP_SIZE; r++) begin
                for (int c = 0; c < CONV_OFMAP_SIZE; c++) begin
                    conv_ofmap[r][c] <= '0;
                end
            end
        end else if (step) begin
            conv_ofmap[row][col] <= pix;
            if (col == LAST) begin
                col <= '0;
                // Counters park on the last pixel; conv_done then freezes everything.
                if (row == LAST) begin
                    col       <= LAST;
                    conv_done <= 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv.sv
// Directed bench for conv: hand-derived maps for flat, impulse and ramp inputs,
// completion latency, pause via en, and mid-run reset.
module tb_conv;

    localparam int DW = 8;
    localparam int IS = 128;
    localparam int KS = 3;
    localparam int OS = IS - KS + 1;
    localparam int FULL_EDGES = OS * OS;
    localparam int EDGE_LIMIT = 20000;

    logic               clk;
    logic               reset;
    logic               en;
    logic        [DW-1:0] ifmap   [IS][IS];
    logic signed [DW-1:0] weights [KS][KS];
    logic        [DW-1:0] ofmap   [OS][OS];
    logic               done;

    logic [DW-1:0] exp_map [OS][OS];
    logic [DW-1:0] exp_q [$];
    int            loc_q [$];

    int n_checks;
    int n_errors;

    conv #(
        .DATA_WIDTH     (DW),
        .IFMAP_SIZE     (IS),
        .KERNEL_SIZE    (KS),
        .CONV_OFMAP_SIZE(OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .conv_ifmap(ifmap),
        .weights   (weights),
        .conv_ofmap(ofmap),
        .conv_done (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int map_errs();
        int errs = 0;
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++)
                if (ofmap[r][c] !== exp_map[r][c]) errs++;
        return errs;
    endfunction

    function automatic int nonzero_count();
        int cnt = 0;
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++)
                if (ofmap[r][c] !== '0) cnt++;
        return cnt;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_laplacian();
        for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++)
                weights[i][j] = '0;
        weights[0][1] = -8'sd1;
        weights[1][0] = -8'sd1;
        weights[1][2] = -8'sd1;
        weights[2][1] = -8'sd1;
        weights[1][1] = 8'sd4;
    endtask

    task automatic fill_ifmap(input logic [DW-1:0] v);
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++)
                ifmap[r][c] = v;
    endtask

    task automatic fill_exp(input logic [DW-1:0] v);
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++)
                exp_map[r][c] = v;
    endtask

    // Counts enabled-or-not edges from reset release until conv_done is seen.
    task automatic run_to_done(input string tag, input int exp_edges,
                               input int pause_at, input int pause_len);
        int n = 0;
        while (n < EDGE_LIMIT) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
            if (n == pause_at) begin
                en = 1'b0;
                repeat (pause_len) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                check({tag, "_done_in_pause"}, int'(done), 0);
                en = 1'b1;
            end
        end
        check({tag, "_latency"}, n, exp_edges);
    endtask

    task automatic push_spot(input int r, input int c, input logic [DW-1:0] v);
        loc_q.push_back(r * OS + c);
        exp_q.push_back(v);
    endtask

    task automatic drain_spots(input string tag);
        while (exp_q.size() > 0) begin
            int            loc = loc_q.pop_front();
            logic [DW-1:0] v   = exp_q.pop_front();
            check($sformatf("%s_px_%0d_%0d", tag, loc / OS, loc % OS),
                  int'(ofmap[loc / OS][loc % OS]), int'(v));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        en       = 1'b0;
        set_laplacian();
        fill_ifmap(8'd1);

        // reset state
        apply_reset();
        check("reset_done", int'(done), 0);
        check("reset_map_nonzero", nonzero_count(), 0);

        // flat map through the Laplacian gives zero everywhere
        en = 1'b1;
        fill_exp(8'd0);
        run_to_done("ones", FULL_EDGES, -1, 0);
        check("ones_map", map_errs(), 0);

        // impulses: 10 gives 40 at the centre and -10 (clamped) at the neighbours, 100 saturates
        en = 1'b0;
        fill_ifmap(8'd0);
        ifmap[5][5]   = 8'd10;
        ifmap[50][50] = 8'd100;
        fill_exp(8'd0);
        exp_map[4][4]   = 8'd40;
        exp_map[49][49] = 8'd255;
        apply_reset();
        check("impulse_reset_done", int'(done), 0);
        en = 1'b1;
        run_to_done("impulse", FULL_EDGES, -1, 0);
        check("impulse_map", map_errs(), 0);
        push_spot(4, 4, 8'd40);
        push_spot(4, 3, 8'd0);
        push_spot(4, 5, 8'd0);
        push_spot(3, 4, 8'd0);
        push_spot(5, 4, 8'd0);
        push_spot(49, 49, 8'd255);
        push_spot(48, 49, 8'd0);
        drain_spots("impulse");

        // horizontal ramp with an all-ones kernel, paused for 50 cycles mid-run
        en = 1'b0;
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++)
                ifmap[r][c] = DW'(c);
        for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++)
                weights[i][j] = 8'sd1;
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < OS; c++)
                exp_map[r][c] = (9 * c + 9 > 255) ? 8'd255 : DW'(9 * c + 9);
        apply_reset();
        en = 1'b1;
        run_to_done("ramp_pause", FULL_EDGES + 50, 5000, 50);
        check("ramp_map", map_errs(), 0);
        push_spot(0, 0, 8'd9);
        push_spot(10, 27, 8'd252);
        push_spot(10, 28, 8'd255);
        push_spot(125, 125, 8'd255);
        drain_spots("ramp");

        // reset around pixel 1000, then a full rerun
        en = 1'b0;
        set_laplacian();
        fill_ifmap(8'd0);
        ifmap[5][5]   = 8'd10;
        ifmap[50][50] = 8'd100;
        fill_exp(8'd0);
        exp_map[4][4]   = 8'd40;
        exp_map[49][49] = 8'd255;
        apply_reset();
        en = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("abort_pre_px_4_4", int'(ofmap[4][4]), 40);
        check("abort_pre_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_reset_map_nonzero", nonzero_count(), 0);
        check("abort_reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        run_to_done("rerun", FULL_EDGES, -1, 0);
        check("rerun_map", map_errs(), 0);

        // done holds and the map stays frozen regardless of en
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            en = k[0];
        end
        #1;
        check("hold_done", int'(done), 1);
        check("hold_map", map_errs(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
